multicycle_ctrl_fsm: RTL and testbench

Parametrised next-generation main control FSM for the multicycle MIPS-style processor. It sequences fetch, decode, execute, memory and writeback for R-type, lw, sw, beq, bne, j and (optionally) addi. It adds memory wait-state handling with a mem_ready handshake, a bounded wait timeout, and illegal-opcode detection. It drives the datapath mux selects and write strobes and exports state/nextstate for debug.

---
 rtl/multicycle_ctrl_fsm.sv | 221 ++++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM for the multicycle MIPS-style datapath.
// Sequences fetch/decode/execute/memory/writeback, handles memory wait states with a
// bounded timeout (mem_err), and flags unsupported opcodes (illegal).
// Optional feature: define MCCTRL_ADDI_EN to decode addi through ADDIEX/ADDIWB;
// without it, addi is reported as illegal.
module multicycle_ctrl_fsm #(
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned STATE_W  = 4,
    parameter int unsigned TMO_W    = 4,
    parameter int unsigned TMO_MAX  = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                regdst,
    output logic                memtoreg,
    output logic                regwrite,
    output logic                memread,
    output logic                memwrite,
    output logic                IorD,
    output logic                IRWrite,
    output logic [1:0]          alusrcA,
    output logic [1:0]          alusrcB,
    output logic [1:0]          aluop,
    output logic [1:0]          PCsrc,
    output logic                PCwrite,
    output logic                branch,
    output logic                jump,
    output logic                PCEn,
    output logic                illegal,
    output logic                mem_err,
    output logic [STATE_W-1:0]  state,
    output logic [STATE_W-1:0]  nextstate
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StAddiEx = 4'd9,
        StAddiWb = 4'd10,
        StJump   = 4'd11
    } state_e;

    localparam logic [5:0] OpR   = 6'b000000;
    localparam logic [5:0] OpLw  = 6'b100011;
    localparam logic [5:0] OpSw  = 6'b101011;
    localparam logic [5:0] OpBeq = 6'b000100;
    localparam logic [5:0] OpBne = 6'b000101;
    localparam logic [5:0] OpJ   = 6'b000010;
`ifdef MCCTRL_ADDI_EN
    localparam logic [5:0] OpAddi = 6'b001000;
`endif

    localparam bit               TmoEn  = (TMO_MAX != 0);
    localparam logic [TMO_W-1:0] TmoMax = TMO_W'(TMO_MAX);

    state_e           state_q, state_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;
    logic             mem_err_q, mem_err_d;
    logic [5:0]       op;
    logic             wait_st;
    logic             tmo;
    logic             taken;
    logic             live;

    assign op      = 6'(opcode);
    assign wait_st = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
    // Timeout fires in the cycle the wait counter sits at its limit.
    assign tmo     = TmoEn && wait_st && (cnt_q == TmoMax);
    assign taken   = (op == OpBne) ? ~zero : zero;
    // Strobes are suppressed while in reset and during a timeout cycle.
    assign live    = rst && !tmo;

    // Next-state decode, illegal-opcode detect and wait-counter update.
    always_comb begin
        state_d   = StFetch;
        illegal_d = 1'b0;
        case (state_q)
            StFetch:  state_d = mem_ready ? StDecode : StFetch;
            StDecode: begin
                case (op)
                    OpLw, OpSw:   state_d = StMemAdr;
                    OpR:          state_d = StExec;
                    OpBeq, OpBne: state_d = StBranch;
`ifdef MCCTRL_ADDI_EN
                    OpAddi:       state_d = StAddiEx;
`endif
                    OpJ:          state_d = StJump;
                    default: begin
                        state_d   = StFetch;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            StMemAdr: state_d = (op == OpSw) ? StMemWr : StMemRd;
            StMemRd:  state_d = mem_ready ? StMemWb : StMemRd;
            StMemWb:  state_d = StFetch;
            StMemWr:  state_d = mem_ready ? StFetch : StMemWr;
            StExec:   state_d = StAluWb;
            StAluWb:  state_d = StFetch;
            StBranch: state_d = StFetch;
`ifdef MCCTRL_ADDI_EN
            StAddiEx: state_d = StAddiWb;
            StAddiWb: state_d = StFetch;
`endif
            StJump:   state_d = StFetch;
            default:  state_d = StFetch;
        endcase
        if (tmo) begin
            state_d = StFetch;
        end
        // Waiting states hold while mem_ready is low, so a clear covers every state change.
        cnt_d     = (TmoEn && wait_st && !mem_ready && !tmo) ? cnt_q + TMO_W'(1) : '0;
        // Registered so mem_err lines up with the cycle the counter reaches the limit.
        mem_err_d = TmoEn && wait_st && !mem_ready && !tmo && (cnt_q + TMO_W'(1) == TmoMax);
    end

    // State, wait counter and the two status pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StFetch;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            mem_err_q <= mem_err_d;
        end
    end

    // Datapath controls decoded from the current state.
    always_comb begin
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        alusrcA  = 2'b00;
        alusrcB  = 2'b00;
        aluop    = 2'b00;
        PCsrc    = 2'b00;
        PCwrite  = 1'b0;
        branch   = 1'b0;
        jump     = 1'b0;
        if (live) begin
            case (state_q)
                StFetch: begin
                    memread = 1'b1;
                    alusrcB = 2'b01;
                    IRWrite = mem_ready;
                    PCwrite = mem_ready;
                end
                StDecode: alusrcB = 2'b11;
                StMemAdr: begin
                    alusrcA = 2'b01;
                    alusrcB = 2'b10;
                end
                StMemRd: begin
                    memread = 1'b1;
                    IorD    = 1'b1;
                end
                StMemWb: begin
                    regwrite = 1'b1;
                    memtoreg = 1'b1;
                end
                StMemWr: begin
                    memwrite = 1'b1;
                    IorD     = 1'b1;
                end
                StExec: begin
                    alusrcA = 2'b01;
                    aluop   = 2'b10;
                end
                StAluWb: begin
                    regwrite = 1'b1;
                    regdst   = 1'b1;
                end
                StBranch: begin
                    alusrcA = 2'b01;
                    aluop   = 2'b01;
                    branch  = 1'b1;
                    PCsrc   = 2'b01;
                end
`ifdef MCCTRL_ADDI_EN
                StAddiEx: begin
                    alusrcA = 2'b01;
                    alusrcB = 2'b10;
                end
                StAddiWb: regwrite = 1'b1;
`endif
                StJump: begin
                    PCwrite = 1'b1;
                    jump    = 1'b1;
                    PCsrc   = 2'b10;
                end
                default: ;
            endcase
        end
    end

    assign PCEn      = PCwrite | (branch & taken);
    assign illegal   = illegal_q;
    assign mem_err   = mem_err_q;
    assign state     = STATE_W'(state_q);
    assign nextstate = rst ? STATE_W'(state_d) : '0;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: the stimulus process pushes one hand-written
// expectation per cycle; the monitor pops and compares on the falling edge.
module tb_multicycle_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       regdst, memtoreg, regwrite, memread, memwrite, IorD, IRWrite;
    logic [1:0] alusrcA, alusrcB, aluop, PCsrc;
    logic       PCwrite, branch, jump, PCEn, illegal, mem_err;
    logic [3:0] state, nextstate;

    multicycle_ctrl_fsm dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .zero      (zero),
        .mem_ready (mem_ready),
        .regdst    (regdst),
        .memtoreg  (memtoreg),
        .regwrite  (regwrite),
        .memread   (memread),
        .memwrite  (memwrite),
        .IorD      (IorD),
        .IRWrite   (IRWrite),
        .alusrcA   (alusrcA),
        .alusrcB   (alusrcB),
        .aluop     (aluop),
        .PCsrc     (PCsrc),
        .PCwrite   (PCwrite),
        .branch    (branch),
        .jump      (jump),
        .PCEn      (PCEn),
        .illegal   (illegal),
        .mem_err   (mem_err),
        .state     (state),
        .nextstate (nextstate)
    );

    always #5 clk = ~clk;

    // Bit order: regdst memtoreg regwrite memread memwrite IorD IRWrite
    //            alusrcA alusrcB aluop PCsrc PCwrite branch jump PCEn illegal mem_err
    function automatic logic [20:0] mk(input logic rd, mtr, rw, mrd, mwr, iord, irw,
                                       input logic [1:0] asa, asb, aop, pcs,
                                       input logic pcw, br, jmp, pcen, ill, merr);
        return {rd, mtr, rw, mrd, mwr, iord, irw, asa, asb, aop, pcs, pcw, br, jmp, pcen,
                ill, merr};
    endfunction

    localparam logic [20:0] ZERO = 21'd0;
    localparam logic [20:0] F0   = mk(0,0,0,1,0,0,0, 2'b00,2'b01,2'b00,2'b00, 0,0,0,0,0,0);
    localparam logic [20:0] F1   = mk(0,0,0,1,0,0,1, 2'b00,2'b01,2'b00,2'b00, 1,0,0,1,0,0);
    localparam logic [20:0] DEC  = mk(0,0,0,0,0,0,0, 2'b00,2'b11,2'b00,2'b00, 0,0,0,0,0,0);
    localparam logic [20:0] MADR = mk(0,0,0,0,0,0,0, 2'b01,2'b10,2'b00,2'b00, 0,0,0,0,0,0);
    localparam logic [20:0] MRD  = mk(0,0,0,1,0,1,0, 2'b00,2'b00,2'b00,2'b00, 0,0,0,0,0,0);
    localparam logic [20:0] MWB  = mk(0,1,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0,0,0,0,0);
    localparam logic [20:0] MWR  = mk(0,0,0,0,1,1,0, 2'b00,2'b00,2'b00,2'b00, 0,0,0,0,0,0);
    localparam logic [20:0] EXE  = mk(0,0,0,0,0,0,0, 2'b01,2'b00,2'b10,2'b00, 0,0,0,0,0,0);
    localparam logic [20:0] AWB  = mk(1,0,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0,0,0,0,0);
    localparam logic [20:0] BRT  = mk(0,0,0,0,0,0,0, 2'b01,2'b00,2'b01,2'b01, 0,1,0,1,0,0);
    localparam logic [20:0] BRN  = mk(0,0,0,0,0,0,0, 2'b01,2'b00,2'b01,2'b01, 0,1,0,0,0,0);
    localparam logic [20:0] JMP  = mk(0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b10, 1,0,1,1,0,0);
    localparam logic [20:0] ILL  = mk(0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0,0,0,1,0);
    localparam logic [20:0] MERR = mk(0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0,0,0,0,1);
`ifdef MCCTRL_ADDI_EN
    localparam logic [20:0] AEX  = mk(0,0,0,0,0,0,0, 2'b01,2'b10,2'b00,2'b00, 0,0,0,0,0,0);
    localparam logic [20:0] AWR  = mk(0,0,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0,0,0,0,0);
`endif

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101, ADDI = 6'b001000, J = 6'b000010, BAD = 6'b111111;

    typedef struct {
        string       nm;
        logic [3:0]  st;
        logic [3:0]  ns;
        logic [20:0] o;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [20:0] outs();
        return {regdst, memtoreg, regwrite, memread, memwrite, IorD, IRWrite, alusrcA,
                alusrcB, aluop, PCsrc, PCwrite, branch, jump, PCEn, illegal, mem_err};
    endfunction

    // Drive one cycle of inputs and queue what the DUT must show during that cycle.
    task automatic cyc(input string nm, input logic [5:0] op, input logic z, input logic mr,
                       input logic [3:0] st, input logic [3:0] ns, input logic [20:0] o);
        exp_t e;
        opcode    = op;
        zero      = z;
        mem_ready = mr;
        e.nm = nm;
        e.st = st;
        e.ns = ns;
        e.o  = o;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare state, nextstate and every control output mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t        e;
            logic [20:0] act;
            e   = sb.pop_front();
            act = outs();
            n_vec++;
            if (act !== e.o || state !== e.st || nextstate !== e.ns) begin
                n_err++;
                $display("FAIL %s: got state=%0d nextstate=%0d outs=%b, want state=%0d nextstate=%0d outs=%b",
                         e.nm, state, nextstate, act, e.st, e.ns, e.o);
            end
        end
    end

    initial begin
        rst       = 1'b0;
        opcode    = R;
        zero      = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (state !== 4'd0 || nextstate !== 4'd0 || outs() !== ZERO) begin
            n_err++;
            $display("FAIL reset_state: got state=%0d nextstate=%0d outs=%b, want all zero",
                     state, nextstate, outs());
        end
        cyc("reset", R, 0, 1, 0, 0, ZERO);
        rst = 1'b1;

        // lw with mem_ready high: 0,1,2,3,4
        cyc("lw_f", LW, 0, 1, 0, 1, F1);
        cyc("lw_dec", LW, 0, 1, 1, 2, DEC);
        cyc("lw_adr", LW, 0, 1, 2, 3, MADR);
        cyc("lw_rd", LW, 0, 1, 3, 4, MRD);
        cyc("lw_wb", LW, 0, 1, 4, 0, MWB);
        // R-type
        cyc("r_f", R, 0, 1, 0, 1, F1);
        cyc("r_dec", R, 0, 1, 1, 6, DEC);
        cyc("r_exe", R, 0, 1, 6, 7, EXE);
        cyc("r_wb", R, 0, 1, 7, 0, AWB);
        // sw
        cyc("sw_f", SW, 0, 1, 0, 1, F1);
        cyc("sw_dec", SW, 0, 1, 1, 2, DEC);
        cyc("sw_adr", SW, 0, 1, 2, 5, MADR);
        cyc("sw_wr", SW, 0, 1, 5, 0, MWR);
        // branches
        cyc("beq1_f", BEQ, 1, 1, 0, 1, F1);
        cyc("beq1_dec", BEQ, 1, 1, 1, 8, DEC);
        cyc("beq1_br", BEQ, 1, 1, 8, 0, BRT);
        cyc("beq0_f", BEQ, 0, 1, 0, 1, F1);
        cyc("beq0_dec", BEQ, 0, 1, 1, 8, DEC);
        cyc("beq0_br", BEQ, 0, 1, 8, 0, BRN);
        cyc("bne1_f", BNE, 1, 1, 0, 1, F1);
        cyc("bne1_dec", BNE, 1, 1, 1, 8, DEC);
        cyc("bne1_br", BNE, 1, 1, 8, 0, BRN);
        cyc("bne0_f", BNE, 0, 1, 0, 1, F1);
        cyc("bne0_dec", BNE, 0, 1, 1, 8, DEC);
        cyc("bne0_br", BNE, 0, 1, 8, 0, BRT);
        // fetch with three wait cycles, then j
        for (int i = 0; i < 3; i++) cyc("fwait", J, 0, 0, 0, 0, F0);
        cyc("fwait_done", J, 0, 1, 0, 1, F1);
        cyc("j_dec", J, 0, 1, 1, 11, DEC);
        cyc("j_jmp", J, 0, 1, 11, 0, JMP);
        // addi
        cyc("addi_f", ADDI, 0, 1, 0, 1, F1);
`ifdef MCCTRL_ADDI_EN
        cyc("addi_dec", ADDI, 0, 1, 1, 9, DEC);
        cyc("addi_ex", ADDI, 0, 1, 9, 10, AEX);
        cyc("addi_wb", ADDI, 0, 1, 10, 0, AWR);
`else
        cyc("addi_dec", ADDI, 0, 1, 1, 0, DEC);
        cyc("addi_ill", J, 0, 1, 0, 1, F1 | ILL);
        cyc("addi_j_dec", J, 0, 1, 1, 11, DEC);
        cyc("addi_j_jmp", J, 0, 1, 11, 0, JMP);
`endif
        // illegal opcode, pulse lasts one cycle
        cyc("bad_f", BAD, 0, 1, 0, 1, F1);
        cyc("bad_dec", BAD, 0, 1, 1, 0, DEC);
        cyc("bad_ill", R, 0, 1, 0, 1, F1 | ILL);
        cyc("bad_r_dec", R, 0, 1, 1, 6, DEC);
        cyc("bad_r_exe", R, 0, 1, 6, 7, EXE);
        cyc("bad_r_wb", R, 0, 1, 7, 0, AWB);
        // sw timeout: 15 wait cycles, then mem_err with strobes dropped
        cyc("swt_f", SW, 0, 1, 0, 1, F1);
        cyc("swt_dec", SW, 0, 1, 1, 2, DEC);
        cyc("swt_adr", SW, 0, 1, 2, 5, MADR);
        for (int i = 0; i < 15; i++) cyc("swt_wait", SW, 0, 0, 5, 5, MWR);
        n_vec++;
        if (mem_err !== 1'b1 || memwrite !== 1'b0 || IorD !== 1'b0 || state !== 4'd5 ||
            nextstate !== 4'd0) begin
            n_err++;
            $display("FAIL wait_expired: got mem_err=%b memwrite=%b IorD=%b state=%0d nextstate=%0d",
                     mem_err, memwrite, IorD, state, nextstate);
        end
        cyc("swt_tmo", SW, 0, 0, 5, 0, MERR);
        // fetch timeout retries the fetch
        for (int i = 0; i < 15; i++) cyc("ft_wait", J, 0, 0, 0, 0, F0);
        cyc("ft_tmo", J, 0, 0, 0, 0, MERR);
        cyc("ft_retry", J, 0, 1, 0, 1, F1);
        cyc("ft_dec", J, 0, 1, 1, 11, DEC);
        cyc("ft_jmp", J, 0, 1, 11, 0, JMP);
        // reset during MEMRD aborts at once; fetch restarts after release
        cyc("rr_f", LW, 0, 1, 0, 1, F1);
        cyc("rr_dec", LW, 0, 1, 1, 2, DEC);
        cyc("rr_adr", LW, 0, 1, 2, 3, MADR);
        cyc("rr_rd", LW, 0, 0, 3, 3, MRD);
        rst = 1'b0;
        cyc("rr_rst", LW, 0, 1, 0, 0, ZERO);
        cyc("rr_hold", LW, 0, 1, 0, 0, ZERO);
        rst = 1'b1;
        cyc("rr_f2", LW, 0, 1, 0, 1, F1);
        cyc("rr_dec2", LW, 0, 1, 1, 2, DEC);
        cyc("rr_adr2", LW, 0, 1, 2, 3, MADR);
        cyc("rr_rd2", LW, 0, 1, 3, 4, MRD);
        cyc("rr_wb2", LW, 0, 1, 4, 0, MWB);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
